alu_control_pipe: RTL and testbench

//  Registered, handshaked successor of the combinational ALU control decoder.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_op_decode.sv | 63 ++++++
 rtl/alu_control_pipe.sv | 103 ++++++++++
 tb/tb_alu_control_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control pipeline:
// operation codes, opcode patterns and FSM encodings.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_ILL   = 4'b1111;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/opcode decode table.
// First matching row wins; no match gives the illegal code.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int OPW = 11
) (
  input  logic [1:0]     i_alu_op,
  input  logic [OPW-1:0] i_opcode_field,
  output logic [3:0]     o_operation,
  output logic           o_multi,
  output logic           o_illegal
);

  logic [10:0] w_lo;
  logic        w_hi_zero;

  assign w_lo      = i_opcode_field[10:0];
  assign w_hi_zero = ((i_opcode_field >> 11) == '0);

  // Priority decode: 00 -> ADD, X1 -> PASS_B, 1X -> opcode table
  always_comb begin
    o_operation = ALU_ILL;
    o_multi     = 1'b0;
    o_illegal   = 1'b1;
    if (i_alu_op == 2'b00) begin
      o_operation = ALU_ADD;
      o_illegal   = 1'b0;
    end else if (i_alu_op[0]) begin
      o_operation = ALU_PASSB;
      o_illegal   = 1'b0;
    end else if (w_hi_zero) begin
      case (w_lo)
        OPC_ADD: begin
          o_operation = ALU_ADD;
          o_illegal   = 1'b0;
        end
        OPC_SUB: begin
          o_operation = ALU_SUB;
          o_illegal   = 1'b0;
        end
        OPC_AND: begin
          o_operation = ALU_AND;
          o_illegal   = 1'b0;
        end
        OPC_ORR: begin
          o_operation = ALU_ORR;
          o_illegal   = 1'b0;
        end
        OPC_MUL: begin
          o_operation = ALU_MUL;
          o_multi     = 1'b1;
          o_illegal   = 1'b0;
        end
        default: begin
          o_operation = ALU_ILL;
          o_illegal   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered, handshaked ALU control with MUL sequencing
// and a saturating illegal-opcode counter.
module alu_control_pipe
  import alu_pkg::*;
#(
  parameter int OPW        = 11,
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [1:0]       i_alu_op,
  input  logic [OPW-1:0]   i_opcode_field,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [3:0]       o_operation,
  output logic             o_op_multi,
  output logic             o_op_illegal,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam int CW = $clog2(MUL_CYCLES) + 1;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_operation;
  logic             r_multi;
  logic             r_illegal;
  logic [CNT_W-1:0] r_illegal_cnt;

  logic [3:0] w_dec_op;
  logic       w_dec_multi;
  logic       w_dec_ill;
  logic       w_in_ready;
  logic       w_accept;

  alu_op_decode #(
    .OPW(OPW)
  ) u_dec (
    .i_alu_op      (i_alu_op),
    .i_opcode_field(i_opcode_field),
    .o_operation   (w_dec_op),
    .o_multi       (w_dec_multi),
    .o_illegal     (w_dec_ill)
  );

  // HOLD passes out_ready through so a draining slot can refill
  assign w_in_ready = (r_state == ST_IDLE) |
                      ((r_state == ST_HOLD) & i_out_ready);
  assign w_accept   = i_in_valid & w_in_ready;

  assign o_in_ready    = w_in_ready;
  assign o_out_valid   = (r_state == ST_HOLD);
  assign o_operation   = r_operation;
  assign o_op_multi    = r_multi;
  assign o_op_illegal  = r_illegal;
  assign o_illegal_cnt = r_illegal_cnt;

  // Sequencing FSM: MUL counts down in BUSY before presenting
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= w_dec_multi ? ST_BUSY : ST_HOLD;
      r_cnt   <= CW'(MUL_CYCLES - 1);
    end else if (r_state == ST_BUSY) begin
      if (r_cnt == CW'(1)) begin
        r_state <= ST_HOLD;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end else if ((r_state == ST_HOLD) & i_out_ready) begin
      r_state <= ST_IDLE;
    end
  end

  // Decode result captured on accept, held until replaced
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_operation <= 4'b0000;
      r_multi     <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_operation <= w_dec_op;
      r_multi     <= w_dec_multi;
      r_illegal   <= w_dec_ill;
    end
  end

  // Saturating count of accepted illegal decodes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_illegal_cnt <= '0;
    end else if (w_accept & w_dec_ill &
                 (r_illegal_cnt != '1)) begin
      r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe with an
// output scoreboard fed from an independent decode model.
module tb_alu_control_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [10:0] opf;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  operation;
  logic        op_multi;
  logic        op_illegal;
  logic [7:0]  illegal_cnt;

  int         nchk = 0;
  int         nerr = 0;
  int         npop = 0;
  int         exp_ill = 0;
  logic [5:0] q[$];

  always #5 clk = ~clk;

  alu_control_pipe #(
    .OPW(11), .MUL_CYCLES(4), .CNT_W(8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_alu_op      (alu_op),
    .i_opcode_field(opf),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_operation   (operation),
    .o_op_multi    (op_multi),
    .o_op_illegal  (op_illegal),
    .o_illegal_cnt (illegal_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  // {operation, multi, illegal}
  function automatic logic [5:0] model(input logic [1:0] a,
                                       input logic [10:0] o);
    if (a == 2'b00) return {4'b0010, 2'b00};
    if (a[0]) return {4'b0111, 2'b00};
    case (o)
      11'b10001011000: return {4'b0010, 2'b00};
      11'b11001011000: return {4'b0110, 2'b00};
      11'b10001010000: return {4'b0000, 2'b00};
      11'b10101010000: return {4'b0001, 2'b00};
      11'b10011011000: return {4'b1000, 2'b10};
      default:         return {4'b1111, 2'b01};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_ill = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          logic [5:0] e;
          e = q.pop_front();
          npop++;
          chk("sb_op", 32'(operation), 32'(e[5:2]));
          chk("sb_multi", 32'(op_multi), 32'(e[1]));
          chk("sb_ill", 32'(op_illegal), 32'(e[0]));
        end
      end
      if (in_valid && in_ready) begin
        logic [5:0] m;
        m = model(alu_op, opf);
        q.push_back(m);
        if (m[0] && exp_ill < 255) exp_ill++;
      end
    end
  end

  logic [10:0] seq3 [3];
  logic [3:0]  exp3 [3];
  logic [1:0]  mix_a [6];
  logic [10:0] mix_o [6];
  bit          seen;

  initial begin
    seq3 = '{11'b10001011000, 11'b10001010000, 11'b10101010000};
    exp3 = '{4'b0010, 4'b0000, 4'b0001};
    mix_a = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11};
    mix_o = '{11'b01010101010, 11'b11001011000, 11'b10011011000,
              11'b10001011001, 11'b10011011000, 11'b11111111111};

    rst = 1'b1;
    in_valid = 1'b0;
    alu_op = 2'b00;
    opf = '0;
    out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_operation", 32'(operation), 32'd0);
    chk("rst_multi", 32'(op_multi), 32'd0);
    chk("rst_illegal", 32'(op_illegal), 32'd0);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single SUB, latency 1
    in_valid = 1'b1; alu_op = 2'b10; opf = 11'b11001011000;
    @(negedge clk);
    chk("sub_in_ready", 32'(in_ready), 32'd1);
    chk("sub_pre_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_op", 32'(operation), 32'h6);

    // back-to-back ADD, AND, ORR
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        in_valid = 1'b1; alu_op = 2'b10; opf = seq3[i];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_op", 32'(operation), 32'(exp3[i-1]));
      end
    end

    // mixed ALUOp / opcode patterns through the scoreboard
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; alu_op = mix_a[i]; opf = mix_o[i];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mix_cnt", 32'(illegal_cnt), 32'(exp_ill));
    chk("mix_drained", 32'(q.size()), 32'd0);

    // MUL: 3 busy cycles, valid on the 4th
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 2'b10; opf = 11'b10011011000;
    @(posedge clk); #1;
    opf = 11'b11001011000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("mul_busy_ready", 32'(in_ready), 32'd0);
      chk("mul_busy_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("mul_valid", 32'(out_valid), 32'd1);
    chk("mul_op", 32'(operation), 32'h8);
    chk("mul_multi", 32'(op_multi), 32'd1);
    chk("mul_passthru", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);

    // stall in HOLD for 5 cycles
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = 2'b10; opf = 11'b10101010000;
    @(posedge clk); #1;
    opf = 11'b10001010000;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_op", 32'(operation), 32'h1);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hold_drained", 32'(q.size()), 32'd0);

    // 300 illegal accepts saturate the counter
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 2'b10; opf = 11'b11111111111;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("ill_op", 32'(operation), 32'hF);
    chk("ill_flag", 32'(op_illegal), 32'd1);
    chk("ill_sat", 32'(illegal_cnt), 32'd255);
    chk("ill_model", 32'(illegal_cnt), 32'(exp_ill));

    // reset during BUSY drops the MUL
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 2'b10; opf = 11'b10011011000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_busy_novalid", 32'(seen), 32'd0);
    chk("rst_busy_ready", 32'(in_ready), 32'd1);
    chk("rst_busy_cnt", 32'(illegal_cnt), 32'd0);

    // recovery after reset
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 2'b00; opf = 11'b10001010000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_op", 32'(operation), 32'h2);
    repeat (2) @(negedge clk);
    chk("final_q_empty", 32'(q.size()), 32'd0);
    chk("final_pops_seen", 32'(npop > 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
